eclair_int_ctrl: RTL and testbench
==================================

# eclair_int_ctrl

Interrupt controller on the CPU side of the ECLair external interrupt lines. It captures falling edges on the eight active-low `int_n` lines into a pending register and applies a CPU-writable mask. It presents the highest-priority unmasked request to the CPU core as `irq` plus a 3-bit vector, then tracks the single in-service interrupt through an acknowledge / end-of-interrupt handshake.

## Interface
- `RESET_MASK`, default 8'h00: mask value after reset; bit = 1 enables that line.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `int_n`, input, 8: external interrupt lines, active-low, asynchronous to `clk`. Bit 0 has the highest priority.
- `mask_wr`, input, 1: write strobe for the mask register.
- `mask_wdata`, input, 8: new mask value, loaded when `mask_wr` = 1.
- `mask`, output, 8: current mask register.
- `pending`, output, 8: current pending register.
- `irq`, output, 1: interrupt request to the CPU; registered.
- `vector`, output, 3: number of the requested line while in REQ; the latched in-service line while in SERVICE.
- `int_ack`, input, 1: one-cycle acknowledge from the CPU.
- `in_service`, output, 1: high while an interrupt is being serviced.
- `eoi`, input, 1: one-cycle end-of-interrupt from the CPU.

## Operation
**Input stage**
- `int_n` is sampled into `in_q`, then delayed into `in_d`.
- `fall[i] = in_d[i] & ~in_q[i]`.
- Reset values: `in_q` and `in_d` = 8'hFF. A line held low through reset therefore produces exactly one event after reset release.

**Pending and candidate**
- `pending[i]` is set on `fall[i]`. It is cleared only when that line is acknowledged.
- Masking never clears pending bits. A masked line stays pending and requests once it is unmasked.
- `cand = pending & mask`. The priority encoder selects the lowest set index of `cand`.

**State machine (IDLE / REQ / SERVICE)**
- IDLE: if `cand` ≠ 0, go to REQ.
- REQ:
  - `irq` = 1.
  - `vector` tracks the live priority encode, so a higher-priority arrival replaces the lower one before ack.
  - `int_ack` = 1: latch `vector`, clear that pending bit, go to SERVICE.
  - `cand` = 0 (for example after a mask write) with no ack: return to IDLE and drop `irq`.
- SERVICE:
  - `irq` = 0, `in_service` = 1, `vector` is held.
  - New edges still set pending bits.
  - `eoi` = 1: go to IDLE.
- No nesting: at most one interrupt is in service at a time.

**Boundary rules**
- A new edge on line k in the same cycle that acknowledges line k: the set wins, so `pending[k]` stays 1 and the new event is kept.
- `int_ack` outside REQ is ignored. `eoi` outside SERVICE is ignored. `int_ack` and `eoi` asserted together are handled by the current state only.
- `mask_wr` in the same cycle as `int_ack`: the acknowledge uses the pre-write `cand` and `vector`; the new mask takes effect the next cycle.
- Edges on already-pending lines are merged; there is no counting.

**Reset (also asserted mid-operation)**
- State = IDLE.
- `irq` = 0, `in_service` = 0, `vector` = 0.
- `pending` = 0, `mask` = `RESET_MASK`.
- Any in-service interrupt is abandoned without needing `eoi`.

## Timing
- `int_n` low, first sampled at edge 0 → `pending` set after edge 1 → `irq` high after edge 2. With `INT_SYNC_EN`, add 2 cycles.
- Minimum `int_n` low pulse: 1 clock period plus the setup margin. A line must return high for at least 1 sampled cycle before its next edge can be seen.
- `int_ack` sampled high in REQ → after the same edge: `irq` = 0, `in_service` = 1, the pending bit is cleared.
- `eoi` sampled high in SERVICE → IDLE after that edge. If `cand` ≠ 0, `irq` = 1 one cycle later.
- `mask` updates on the edge where `mask_wr` is sampled high.

## Configuration
- `ECLAIR_INT_SYNC_EN` defined:
  - Two additional flops per line ahead of `in_q`, for metastability protection.
  - Synchronizer reset value is 1.
  - Edge-to-`irq` latency is 4 cycles.
- Not defined:
  - `int_n` feeds `in_q` directly.
  - Latency is 2 cycles, for use when the lines are already synchronous to `clk`.

## Test plan
- Reset release with `int_n` = 8'hFF, then `mask_wr` 8'h01; pulse `int_n[0]` low for 5 cycles → `irq` = 1 at the documented latency, `vector` = 0; `int_ack` → `irq` = 0, `in_service` = 1, `pending` = 0; `eoi` → `in_service` = 0.
- Mask 8'hFF; simultaneous falls on lines 5 and 2 → `vector` = 2; ack and eoi → `irq` reasserts with `vector` = 5.
- In REQ for line 6, a fall on line 1 before ack → `vector` changes 6 → 1; ack services line 1 and `pending[6]` stays 1.
- Mask 8'h00 with a fall on line 3 → `pending` = 8'h08 and `irq` = 0; write mask 8'h08 → `irq` = 1, `vector` = 3. During REQ, write mask 0 → `irq` drops and the state returns to IDLE.
- A fall on line 4 in the same cycle that acknowledges line 4 → after ack `pending[4]` = 1; after eoi → `irq` = 1, `vector` = 4.
- `rst_n` asserted during SERVICE → `in_service`, `irq`, `pending` = 0 and `mask` = `RESET_MASK` immediately, without a clock edge; `int_ack` and `eoi` pulses in IDLE have no effect.

Source files
------------

// File: rtl/eclair_int_if.sv
// Interrupt controller CPU-side signal bundle: external lines, mask port, request/ack/eoi handshake.
// The master side (CPU/stimulus) drives lines, mask writes and handshakes; the slave is the controller.
interface eclair_int_if;
  logic [7:0] int_n;
  logic       mask_wr;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       irq;
  logic [2:0] vector;
  logic       int_ack;
  logic       in_service;
  logic       eoi;

  modport master (
    output int_n, mask_wr, mask_wdata, int_ack, eoi,
    input  mask, pending, irq, vector, in_service
  );

  modport slave (
    input  int_n, mask_wr, mask_wdata, int_ack, eoi,
    output mask, pending, irq, vector, in_service
  );
endinterface

// File: rtl/eclair_int_ctrl.sv
// 8-line falling-edge interrupt controller with mask, fixed priority (bit 0 highest), single in-service slot.
// Edge-to-irq latency 2 cycles; ECLAIR_INT_SYNC_EN adds a 2-flop synchronizer per line (latency 4).
module eclair_int_ctrl #(
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  eclair_int_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] in_src;
  logic [7:0] in_q, in_d;
  logic [7:0] fall;
  logic [7:0] pending_q, pending_nxt;
  logic [7:0] mask_q;
  logic [7:0] cand;
  logic       cand_any;
  logic [7:0] ack_clr;
  logic [2:0] enc;
  logic [2:0] vec_q, vec_nxt;
  logic       irq_q, in_service_q;

`ifdef ECLAIR_INT_SYNC_EN
  logic [7:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= bus.int_n;
      sync2 <= sync1;
    end
  end

  assign in_src = sync2;
`else
  assign in_src = bus.int_n;
`endif

  // in_q/in_d reset high so a line held low through reset yields exactly one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 8'hFF;
      in_d <= 8'hFF;
    end else begin
      in_q <= in_src;
      in_d <= in_q;
    end
  end

  assign fall     = in_d & ~in_q;
  assign cand     = pending_q & mask_q;
  assign cand_any = |cand;

  always_comb begin
    enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) enc = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    ack_clr   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (cand_any) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.int_ack && cand_any) begin
          state_nxt = ST_SERVICE;
          vec_nxt   = enc;
          ack_clr   = 8'h01 << enc;
        end else if (!cand_any) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A fresh edge on the line being acknowledged wins over the clear.
  assign pending_nxt = (pending_q & ~ack_clr) | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pending_q    <= 8'h00;
      mask_q       <= RESET_MASK;
      vec_q        <= 3'd0;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending_q    <= pending_nxt;
      vec_q        <= vec_nxt;
      irq_q        <= (state_nxt == ST_REQ);
      in_service_q <= (state_nxt == ST_SERVICE);
      if (bus.mask_wr) mask_q <= bus.mask_wdata;
    end
  end

  assign bus.mask       = mask_q;
  assign bus.pending    = pending_q;
  assign bus.irq        = irq_q;
  assign bus.in_service = in_service_q;
  assign bus.vector     = (state == ST_REQ) ? enc : vec_q;

endmodule

// File: tb/tb_eclair_int_ctrl.sv
// Bench for eclair_int_ctrl: directed vector table, reset-during-service sequence, then random traffic vs a model.
module tb_eclair_int_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  eclair_int_if bus ();

  eclair_int_ctrl #(.RESET_MASK(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef ECLAIR_INT_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  // Reference model: sample history of int_n, pending/mask sets, and the current activity.
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic [7:0] m_smp [0:S+1];
  logic [7:0] m_pend, m_mask;
  int         m_mode;
  int         m_lat;

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= S + 1; i++) m_smp[i] = 8'hFF;
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_mode = M_IDLE;
    m_lat  = 0;
  endtask

  task automatic model_edge();
    logic [7:0] cand, edges, pend_new;
    cand     = m_pend & m_mask;
    edges    = m_smp[S+1] & ~m_smp[S];
    pend_new = m_pend;
    if (m_mode == M_IDLE) begin
      if (cand != 0) m_mode = M_REQ;
    end else if (m_mode == M_REQ) begin
      if (bus.int_ack && cand != 0) begin
        m_lat = lowest(cand);
        pend_new[m_lat] = 1'b0;
        m_mode = M_SVC;
      end else if (cand == 0) begin
        m_mode = M_IDLE;
      end
    end else if (bus.eoi) begin
      m_mode = M_IDLE;
    end
    m_pend = pend_new | edges;
    if (bus.mask_wr) m_mask = bus.mask_wdata;
    for (int i = S + 1; i > 0; i--) m_smp[i] = m_smp[i-1];
    m_smp[0] = bus.int_n;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [2:0] ev;
    ev = (m_mode == M_REQ) ? 3'(lowest(m_pend & m_mask)) : 3'(m_lat);
    chk({tag, "_irq"},  {7'd0, bus.irq},        {7'd0, m_mode == M_REQ});
    chk({tag, "_svc"},  {7'd0, bus.in_service}, {7'd0, m_mode == M_SVC});
    chk({tag, "_vec"},  {5'd0, bus.vector},     {5'd0, ev});
    chk({tag, "_pend"}, bus.pending,            m_pend);
    chk({tag, "_mask"}, bus.mask,               m_mask);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [7:0] n, input logic mwr, input logic [7:0] md,
                        input logic ack, input logic e);
    bus.int_n      = n;
    bus.mask_wr    = mwr;
    bus.mask_wdata = md;
    bus.int_ack    = ack;
    bus.eoi        = e;
  endtask

  typedef struct {
    logic [7:0] int_n;
    logic       mwr;
    logic [7:0] mdat;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] vec;
    logic       svc;
    logic [7:0] pend;
    logic [7:0] mask;
  } vec_t;

  localparam int NROWS = 45;
  vec_t tbl [NROWS];

  function automatic vec_t mk(input logic [7:0] n, input logic mwr, input logic [7:0] md,
                              input logic ack, input logic e, input logic irq,
                              input logic [2:0] v, input logic svc,
                              input logic [7:0] p, input logic [7:0] m);
    vec_t r;
    r.int_n = n; r.mwr = mwr; r.mdat = md; r.ack = ack; r.eoi = e;
    r.irq = irq; r.vec = v; r.svc = svc; r.pend = p; r.mask = m;
    return r;
  endfunction

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_irq"},  {7'd0, bus.irq},        8'h00);
    chk({tag, "_svc"},  {7'd0, bus.in_service}, 8'h00);
    chk({tag, "_vec"},  {5'd0, bus.vector},     8'h00);
    chk({tag, "_pend"}, bus.pending,            8'h00);
    chk({tag, "_mask"}, bus.mask,               8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //             int_n  wr dat    ak eo | irq vec  svc pend   mask
    tbl[0]  = mk(8'hFF, 1, 8'h01, 0, 0,  0, 3'd0, 0, 8'h00, 8'h01);
    tbl[1]  = mk(8'hFE, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h00, 8'h01);
    tbl[2]  = mk(8'hFE, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h01, 8'h01);
    tbl[3]  = mk(8'hFE, 0, 8'h00, 0, 0,  1, 3'd0, 0, 8'h01, 8'h01);
    tbl[4]  = mk(8'hFE, 0, 8'h00, 0, 0,  1, 3'd0, 0, 8'h01, 8'h01);
    tbl[5]  = mk(8'hFE, 0, 8'h00, 1, 0,  0, 3'd0, 1, 8'h00, 8'h01);
    tbl[6]  = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd0, 1, 8'h00, 8'h01);
    tbl[7]  = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd0, 0, 8'h00, 8'h01);
    tbl[8]  = mk(8'hFF, 1, 8'hFF, 0, 0,  0, 3'd0, 0, 8'h00, 8'hFF);
    tbl[9]  = mk(8'hDB, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h00, 8'hFF);
    tbl[10] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h24, 8'hFF);
    tbl[11] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd2, 0, 8'h24, 8'hFF);
    tbl[12] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd2, 1, 8'h20, 8'hFF);
    tbl[13] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd2, 0, 8'h20, 8'hFF);
    tbl[14] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd5, 0, 8'h20, 8'hFF);
    tbl[15] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd5, 1, 8'h00, 8'hFF);
    tbl[16] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd5, 0, 8'h00, 8'hFF);
    tbl[17] = mk(8'hBF, 0, 8'h00, 0, 0,  0, 3'd5, 0, 8'h00, 8'hFF);
    tbl[18] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd5, 0, 8'h40, 8'hFF);
    tbl[19] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h40, 8'hFF);
    tbl[20] = mk(8'hFD, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h40, 8'hFF);
    tbl[21] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd1, 0, 8'h42, 8'hFF);
    tbl[22] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd1, 1, 8'h40, 8'hFF);
    tbl[23] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd1, 0, 8'h40, 8'hFF);
    tbl[24] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h40, 8'hFF);
    tbl[25] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd6, 1, 8'h00, 8'hFF);
    tbl[26] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd6, 0, 8'h00, 8'hFF);
    tbl[27] = mk(8'hFF, 1, 8'h00, 0, 0,  0, 3'd6, 0, 8'h00, 8'h00);
    tbl[28] = mk(8'hF7, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h00, 8'h00);
    tbl[29] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h08, 8'h00);
    tbl[30] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h08, 8'h00);
    tbl[31] = mk(8'hFF, 1, 8'h08, 0, 0,  0, 3'd6, 0, 8'h08, 8'h08);
    tbl[32] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd3, 0, 8'h08, 8'h08);
    tbl[33] = mk(8'hFF, 1, 8'h00, 0, 0,  1, 3'd0, 0, 8'h08, 8'h00);
    tbl[34] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h08, 8'h00);
    tbl[35] = mk(8'hFF, 1, 8'h10, 0, 0,  0, 3'd6, 0, 8'h08, 8'h10);
    tbl[36] = mk(8'hEF, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h08, 8'h10);
    tbl[37] = mk(8'hFF, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h18, 8'h10);
    tbl[38] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd4, 0, 8'h18, 8'h10);
    tbl[39] = mk(8'hEF, 0, 8'h00, 0, 0,  1, 3'd4, 0, 8'h18, 8'h10);
    tbl[40] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd4, 1, 8'h18, 8'h10);
    tbl[41] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd4, 0, 8'h18, 8'h10);
    tbl[42] = mk(8'hFF, 0, 8'h00, 0, 0,  1, 3'd4, 0, 8'h18, 8'h10);
    tbl[43] = mk(8'hFF, 0, 8'h00, 1, 0,  0, 3'd4, 1, 8'h08, 8'h10);
    tbl[44] = mk(8'hFF, 0, 8'h00, 0, 1,  0, 3'd4, 0, 8'h08, 8'h10);

    set_in(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("por_irq",  {7'd0, bus.irq},        8'h00);
    chk("por_svc",  {7'd0, bus.in_service}, 8'h00);
    chk("por_vec",  {5'd0, bus.vector},     8'h00);
    chk("por_pend", bus.pending,            8'h00);
    chk("por_mask", bus.mask,               8'h00);
    rst_n = 1'b1;

`ifndef ECLAIR_INT_SYNC_EN
    for (int r = 0; r < NROWS; r++) begin
      set_in(tbl[r].int_n, tbl[r].mwr, tbl[r].mdat, tbl[r].ack, tbl[r].eoi);
      tick();
      chk($sformatf("row%0d_irq", r),  {7'd0, bus.irq},        {7'd0, tbl[r].irq});
      chk($sformatf("row%0d_vec", r),  {5'd0, bus.vector},     {5'd0, tbl[r].vec});
      chk($sformatf("row%0d_svc", r),  {7'd0, bus.in_service}, {7'd0, tbl[r].svc});
      chk($sformatf("row%0d_pend", r), bus.pending,            tbl[r].pend);
      chk($sformatf("row%0d_mask", r), bus.mask,               tbl[r].mask);
      chk_model($sformatf("row%0d_model", r));
    end
`endif

    // Reset while servicing, then stray ack/eoi in IDLE.
    set_in(8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    set_in(8'hFE, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (S + 3) tick();
    set_in(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("pre_rst_svc", {7'd0, bus.in_service}, 8'h01);
    chk_model("pre_rst");
    set_in(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    async_reset("midrst");
    set_in(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    set_in(8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    set_in(8'hFF, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("idle_hs_irq",  {7'd0, bus.irq},        8'h00);
    chk("idle_hs_svc",  {7'd0, bus.in_service}, 8'h00);
    chk("idle_hs_pend", bus.pending,            8'h00);
    chk_model("idle_hs");

    // Random traffic against the model, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] n;
      n = bus.int_n ^ 8'($urandom & $urandom & $urandom);
      set_in(n, ($urandom_range(0, 15) == 0), 8'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      if (c % 1000 == 999) begin
        async_reset($sformatf("rnd_rst%0d", c));
      end else begin
        tick();
        chk_model($sformatf("rnd%0d", c));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
